// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool with signed ReLU, shift quantisation and saturation.
// Keeps one half-width row of horizontal pair maxima; single-entry output register.
`timescale 1ns/1ps
module maxpool2x2_stream #(
  parameter int CH     = 6,
  parameter int DW     = 32,
  parameter int OW     = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int QSHIFT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH*DW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*OW-1:0] out_data,
  output logic             out_last
);

  localparam int HW  = IMG_W / 2;
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int LIW = (HW > 1) ? $clog2(HW) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CH*DW-1:0] hreg_q;
  logic [CH*DW-1:0] linebuf [HW];
  logic             out_valid_q;
  logic [CH*OW-1:0] out_data_q;
  logic             out_last_q;

  logic             accept, fill_wr, pool_ld;
  logic [LIW-1:0]   lb_idx;
  logic [CH*DW-1:0] lb_rd, hmax;
  logic [CH*OW-1:0] q_data;

  function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Negative -> 0; non-negative values shift logically since the sign bit is clear.
  function automatic logic [OW-1:0] quant(input logic [DW-1:0] m);
    logic [DW-1:0] q;
    if (m[DW-1]) return '0;
    q = m >> QSHIFT;
    if ((q >> OW) != '0) return '1;
    return q[OW-1:0];
  endfunction

  // Ready is combinational so a draining output slot admits a new pixel in the same cycle.
  assign in_ready  = !clear && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign lb_idx    = LIW'(col_q >> 1);
  assign fill_wr   = accept && !row_q[0] && col_q[0];
  assign pool_ld   = accept &&  row_q[0] && col_q[0];
  assign lb_rd     = linebuf[lb_idx];

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    col_d = col_q + 1'b1;
    row_d = row_q;
    if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end
  end

  always_comb begin
    hmax   = '0;
    q_data = '0;
    for (int c = 0; c < CH; c++) begin
      hmax[c*DW +: DW]   = smax(hreg_q[c*DW +: DW], in_data[c*DW +: DW]);
      q_data[c*OW +: OW] = quant(smax(lb_rd[c*DW +: DW], hmax[c*DW +: DW]));
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      hreg_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (clear) begin
      col_q       <= '0;
      row_q       <= '0;
      hreg_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (accept) begin
        col_q <= col_d;
        row_q <= row_d;
        if (!col_q[0]) hreg_q <= in_data;
      end
      if (pool_ld) begin
        out_data_q  <= q_data;
        out_valid_q <= 1'b1;
        out_last_q  <= (row_q == ROW_LAST) && (col_q == COL_LAST);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: the line buffer is deliberately not reset; each entry is written in a FILL row
  // before the following POOL row reads it, so its power-up contents never matter.
  always_ff @(posedge clk) begin
    if (fill_wr) linebuf[lb_idx] <= hmax;
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: default 6ch/28x28 build plus a tiny 2ch/4x2 build.
`timescale 1ns/1ps
module tb_maxpool2x2_stream;

  localparam int CH = 6, DW = 32, OW = 8, W = 28, H = 28;
  localparam int NPIX = W * H;
  localparam int NOUT = (W / 2) * (H / 2);

  logic clk = 1'b0, rst_n = 1'b0;
  logic clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_last;
  logic [CH*DW-1:0] in_data = '0;
  logic [CH*OW-1:0] out_data;

  logic p_clear = 1'b0, p_in_valid = 1'b0, p_out_ready = 1'b1;
  logic p_in_ready, p_out_valid, p_out_last;
  logic [31:0] p_in_data = '0;
  logic [7:0]  p_out_data;

  always #5 clk = ~clk;

  maxpool2x2_stream #(.CH(CH), .DW(DW), .OW(OW), .IMG_W(W), .IMG_H(H), .QSHIFT(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last));

  maxpool2x2_stream #(.CH(2), .DW(16), .OW(4), .IMG_W(4), .IMG_H(2), .QSHIFT(0)) dut_small (
    .clk(clk), .rst_n(rst_n), .clear(p_clear), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_data(p_in_data), .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
    .out_last(p_out_last));

  int n_checks = 0, n_fail = 0;
  logic [CH*DW-1:0] frame_mem [NPIX];
  logic [CH*OW-1:0] got_data [$];
  bit               got_last [$];
  int  stall_ready_viol, stall_data_viol, drv_cycles;
  bit  drv_timeout;

  task automatic load_ramp();
    for (int r = 0; r < H; r++)
      for (int x = 0; x < W; x++)
        for (int c = 0; c < CH; c++)
          frame_mem[r*W+x][c*DW +: DW] = DW'((r*W + x + c) << 8);
  endtask

  task automatic set_px(input int r, input int x, input logic [DW-1:0] v);
    for (int c = 0; c < CH; c++) frame_mem[r*W+x][c*DW +: DW] = v;
  endtask

  // Output (i,j) of the ramp: bottom-right pixel of the window, shifted back down, clipped at 255.
  function automatic logic [CH*OW-1:0] ramp_exp(input int k);
    logic [CH*OW-1:0] res;
    int i, j, v;
    i = k / (W/2);
    j = k % (W/2);
    res = '0;
    for (int c = 0; c < CH; c++) begin
      v = (2*i+1)*W + 2*j + 1 + c;
      if (v > 255) v = 255;
      res[c*OW +: OW] = OW'(v);
    end
    return res;
  endfunction

  // Streams npix pixels from frame_mem, collecting outputs; optional 10-ish cycle stall on first output.
  task automatic drive(input int npix, input int stall_len);
    int p = 0, stall_left = 0;
    bit stall_used = 0;
    logic [CH*OW-1:0] held = '0;
    got_data.delete();
    got_last.delete();
    stall_ready_viol = 0;
    stall_data_viol  = 0;
    drv_cycles       = 0;
    drv_timeout      = 0;
    forever begin
      @(negedge clk);
      if (stall_len > 0 && !stall_used && out_valid) begin
        stall_used = 1;
        stall_left = stall_len;
        held       = out_data;
      end
      out_ready = (stall_left == 0);
      in_valid  = (p < npix);
      in_data   = frame_mem[p % NPIX];
      #1;
      drv_cycles++;
      if (stall_left > 0) begin
        if (in_ready !== 1'b0) stall_ready_viol++;
        if (out_valid !== 1'b1 || out_data !== held) stall_data_viol++;
        stall_left--;
      end
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      if (in_valid && in_ready) p++;
      else if (!in_valid && !out_valid) break;
      if (drv_cycles > 2*npix + 100) begin
        drv_timeout = 1;
        break;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_ramp();
    int bad = 0, first = 0, nl = 0;
    load_ramp();
    drive(NPIX, 0);
    n_checks++; if (drv_timeout !== 1'b0) begin n_fail++; $display("FAIL ramp_timeout: stream did not finish within budget"); end
    n_checks++; if (got_data.size() !== NOUT) begin n_fail++; $display("FAIL ramp_count: got %0d expected %0d", got_data.size(), NOUT); end
    for (int k = got_data.size() - 1; k >= 0; k--)
      if (got_data[k] !== ramp_exp(k)) begin bad++; first = k; end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ramp_values: %0d bad, first %0d got %h expected %h", bad, first, got_data[first], ramp_exp(first)); end
    n_checks++; if (got_data[0][7:0] !== 8'd29) begin n_fail++; $display("FAIL ramp_first: got %0d expected 29", got_data[0][7:0]); end
    n_checks++; if (got_data[NOUT-1][7:0] !== 8'd255) begin n_fail++; $display("FAIL ramp_saturated_last: got %0d expected 255", got_data[NOUT-1][7:0]); end
    foreach (got_last[k]) if (got_last[k]) nl++;
    n_checks++; if (nl !== 1 || got_last[NOUT-1] !== 1'b1) begin n_fail++; $display("FAIL ramp_out_last: got %0d markers (last flag %b) expected 1 on final", nl, got_last[NOUT-1]); end
    n_checks++; if (drv_cycles > NPIX + 2) begin n_fail++; $display("FAIL ramp_throughput: got %0d cycles expected <= %0d", drv_cycles, NPIX + 2); end
  endtask

  task automatic test_backpressure();
    int bad = 0, first = 0, nl = 0;
    load_ramp();
    drive(NPIX, 10);
    n_checks++; if (stall_ready_viol !== 0) begin n_fail++; $display("FAIL bp_in_ready: got %0d stalled cycles with in_ready=1 expected 0", stall_ready_viol); end
    n_checks++; if (stall_data_viol !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d stalled cycles with changed output expected 0", stall_data_viol); end
    n_checks++; if (got_data.size() !== NOUT) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", got_data.size(), NOUT); end
    for (int k = got_data.size() - 1; k >= 0; k--)
      if (got_data[k] !== ramp_exp(k)) begin bad++; first = k; end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_values: %0d bad, first %0d got %h expected %h", bad, first, got_data[first], ramp_exp(first)); end
    foreach (got_last[k]) if (got_last[k]) nl++;
    n_checks++; if (nl !== 1) begin n_fail++; $display("FAIL bp_out_last: got %0d markers expected 1", nl); end
    n_checks++; if (drv_cycles !== NPIX + 12) begin n_fail++; $display("FAIL bp_cycles: got %0d expected %0d", drv_cycles, NPIX + 12); end
  endtask

  task automatic test_back_to_back();
    int bad = 0, first = 0, nl = 0;
    load_ramp();
    drive(2*NPIX, 0);
    n_checks++; if (got_data.size() !== 2*NOUT) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", got_data.size(), 2*NOUT); end
    n_checks++; if (got_data[NOUT] !== got_data[0] || got_data[0] !== ramp_exp(0)) begin n_fail++; $display("FAIL b2b_first: got %h / %h expected %h", got_data[0], got_data[NOUT], ramp_exp(0)); end
    for (int k = got_data.size() - 1; k >= 0; k--)
      if (got_data[k] !== ramp_exp(k % NOUT)) begin bad++; first = k; end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_values: %0d bad, first %0d got %h expected %h", bad, first, got_data[first], ramp_exp(first % NOUT)); end
    foreach (got_last[k]) if (got_last[k]) nl++;
    n_checks++; if (nl !== 2 || got_last[NOUT-1] !== 1'b1 || got_last[2*NOUT-1] !== 1'b1) begin n_fail++; $display("FAIL b2b_out_last: got %0d markers expected 2 at frame ends", nl); end
    n_checks++; if (drv_cycles !== 2*NPIX + 2) begin n_fail++; $display("FAIL b2b_cycles: got %0d expected %0d", drv_cycles, 2*NPIX + 2); end
  endtask

  task automatic test_neg_sat();
    logic [OW-1:0] expv [7] = '{8'd0, 8'd255, 8'hA3, 8'h50, 8'h30, 8'hFF, 8'd255};
    int nz = 0;
    for (int p = 0; p < NPIX; p++) frame_mem[p] = '0;
    set_px(0, 0, -32'sd5);     set_px(0, 1, -32'sd1);
    set_px(1, 0, -32'sd300);   set_px(1, 1, -32'sd7);
    set_px(0, 2, 32'h1FF00);
    set_px(0, 4, 32'h00A3FF);  set_px(0, 5, 32'h00A200);
    set_px(1, 7, 32'h5000);
    set_px(0, 8, 32'h100);     set_px(1, 8, 32'h3000);   set_px(1, 9, -32'sd1);
    set_px(0, 10, 32'hFFFF);
    set_px(0, 12, 32'h10000);
    drive(NPIX, 0);
    n_checks++; if (got_data.size() !== NOUT) begin n_fail++; $display("FAIL ns_count: got %0d expected %0d", got_data.size(), NOUT); end
    for (int k = 0; k < 7; k++) begin
      n_checks++;
      if (got_data[k] !== {CH{expv[k]}}) begin n_fail++; $display("FAIL ns_window%0d: got %h expected %h", k, got_data[k], {CH{expv[k]}}); end
    end
    for (int k = 7; k < got_data.size(); k++) if (got_data[k] !== '0) nz++;
    n_checks++; if (nz !== 0) begin n_fail++; $display("FAIL ns_zero_rest: got %0d nonzero outputs expected 0", nz); end
  endtask

  task automatic test_clear();
    int bad = 0, first = 0, nl = 0;
    load_ramp();
    drive(5*W + 13, 0);
    n_checks++; if (got_data.size() !== 34) begin n_fail++; $display("FAIL clr_pre_count: got %0d expected 34", got_data.size()); end
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = frame_mem[5*W + 13]; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_in_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin n_fail++; $display("FAIL clr_out_state: got valid %b last %b expected 0 0", out_valid, out_last); end
    drive(NPIX, 0);
    n_checks++; if (got_data.size() !== NOUT) begin n_fail++; $display("FAIL clr_count: got %0d expected %0d", got_data.size(), NOUT); end
    for (int k = got_data.size() - 1; k >= 0; k--)
      if (got_data[k] !== ramp_exp(k)) begin bad++; first = k; end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL clr_values: %0d bad, first %0d got %h expected %h", bad, first, got_data[first], ramp_exp(first)); end
    foreach (got_last[k]) if (got_last[k]) nl++;
    n_checks++; if (nl !== 1 || got_last[NOUT-1] !== 1'b1) begin n_fail++; $display("FAIL clr_out_last: got %0d markers expected 1 on final", nl); end
  endtask

  task automatic test_midframe_reset();
    int bad = 0, first = 0;
    load_ramp();
    drive(99, 0);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = frame_mem[99];
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mr_pending: got valid %b expected 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL mr_async: got valid %b data %h expected 0 0", out_valid, out_data); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    drive(NPIX, 0);
    for (int k = got_data.size() - 1; k >= 0; k--)
      if (got_data[k] !== ramp_exp(k)) begin bad++; first = k; end
    n_checks++; if (got_data.size() !== NOUT || bad !== 0) begin n_fail++; $display("FAIL mr_frame: got %0d outputs, %0d bad (first %0d) expected %0d, 0", got_data.size(), bad, first, NOUT); end
  endtask

  task automatic test_param();
    logic [15:0] ch0, ch1;
    logic [7:0]  pg [$];
    bit          pl [$];
    int p = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      ch0 = 16'(p + 1);
      ch1 = (p == 1) ? 16'd17 : 16'(p + 1);
      p_in_valid = (p < 8);
      p_in_data  = {ch1, ch0};
      #1;
      if (p_out_valid && p_out_ready) begin pg.push_back(p_out_data); pl.push_back(p_out_last); end
      if (p_in_valid && p_in_ready) p++;
    end
    p_in_valid = 1'b0;
    n_checks++; if (pg.size() !== 2) begin n_fail++; $display("FAIL small_count: got %0d expected 2", pg.size()); end
    n_checks++; if (pg[0] !== {4'd15, 4'd6}) begin n_fail++; $display("FAIL small_out0: got %h expected f6", pg[0]); end
    n_checks++; if (pg[1] !== {4'd8, 4'd8}) begin n_fail++; $display("FAIL small_out1: got %h expected 88", pg[1]); end
    n_checks++; if (pl[0] !== 1'b0 || pl[1] !== 1'b1) begin n_fail++; $display("FAIL small_last: got %b%b expected 01", pl[0], pl[1]); end
  endtask

  initial begin
    test_reset();
    test_param();
    test_ramp();
    test_neg_sat();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
